baudot_encoder: RTL and testbench
=================================

Name: baudot_encoder

Overview:
Upstream feeder for the Baudot UART transmitter. Accepts ASCII bytes over a valid/ready handshake and maps each one to a 5-bit ITA2 code. Inserts LTRS/FIGS shift codes whenever the character set changes and periodically re-sends the current shift. Emits codes one at a time over a valid/ready handshake to the transmitter.

Parameters:
SHIFT_REFRESH, 8, number of non-shift codes after which the current shift code is re-sent; 0 disables refresh.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  ASCII character
in_valid  input  1  in_data valid
in_ready  output  1  encoder can accept a byte this cycle
out_code  output  5  ITA2 code; bit0 is the first data bit on the line
out_valid  output  1  out_code valid
out_ready  input  1  transmitter consumes out_code this cycle
shift_state  output  2  00 unknown, 01 LTRS, 10 FIGS
err_unmapped  output  1  one-cycle pulse when an accepted byte has no ITA2 mapping

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, out_code=0, shift_state=00, refresh count=0, err_unmapped=0. in_ready reads 1 from the reset state.
- in_ready = (state==IDLE). A byte is accepted on an edge where in_valid && in_ready.
- Lookup classifies each byte:
  - LTRS class: A–Z, with a–z folded to upper case.
  - FIGS class: 0–9 and - ? : ( ) . , ' / + =.
  - BOTH class: space, CR, LF, NUL.
  - INVALID: everything else.
- Codes (bit0 first): A=00011, E=00001, T=10000, space=00100, CR=01000, LF=00010, NUL=00000, LTRS=11111, FIGS=11011. Digits share codes with the top-row letters: 1=Q=10111, 2=W=10011, 3=E, 4=R=01010, 5=T, 6=Y=10101, 7=U=00111, 8=I=00110, 9=O=11000, 0=P=10110. The full table lives in the package.
- FSM states: IDLE, SHIFT, CHAR.
  - IDLE, accept of an INVALID byte: err_unmapped=1 on the next cycle. Byte dropped, stay IDLE, no output.
  - IDLE, accept of a valid byte: latch code and class.
    - Go to SHIFT if the class is LTRS/FIGS and differs from shift_state (including unknown).
    - Also go to SHIFT if SHIFT_REFRESH!=0 and count==SHIFT_REFRESH.
    - Otherwise go to CHAR.
  - SHIFT: out_valid=1, out_code = shift code for the class. A BOTH-class refresh re-sends the current shift, or LTRS if unknown. On out_ready: update shift_state, count=0, go to CHAR.
  - CHAR: out_valid=1, out_code=latched code. On out_ready: count = count+1 (saturating at SHIFT_REFRESH), go to IDLE.
- Latency: accept at edge N gives out_valid=1 after edge N. A shift insertion adds one extra handshake.
- While out_valid && !out_ready, out_code and out_valid hold stable. No new byte is accepted.
- BOTH-class chars with shift_state=unknown are sent without a shift and leave the state unknown.
- Reset mid-operation: the pending code is discarded, with no partial output after release.
- Throughput: at most one byte per two cycles. in_ready=0 in the cycle a code completes; back-to-back acceptance is not required.

Decomposition:
- Package baudot_pkg holds:
  - ITA2 code constants (LTRS, FIGS, CR, LF, SPACE),
  - class enum (CLS_LTRS, CLS_FIGS, CLS_BOTH, CLS_INVALID),
  - shift_state encoding,
  - FSM state enum.
- One combinational sub-module, baudot_lut: 8-bit ASCII in, 5-bit code plus 2-bit class out. It is exhaustively checkable on its own.

Test Plan:
- After reset, send "A" with out_ready=1 → out stream 11111, 00011. shift_state=01. No err_unmapped.
- Send "A1" → 11111, 00011, 11011, 10111. shift_state=10 at end.
- Send "aa" → 11111, 00011, 00011, i.e. only one shift. Lower case folds to upper.
- After reset, send " " → single 00100. shift_state stays 00.
- Send 0x7E ('~') → err_unmapped pulses once, no out_valid, in_ready back to 1 the next cycle. Then send "E" → 11111, 00001.
- SHIFT_REFRESH=2: send "AAAA" with out_ready=1 → 11111, 00011, 00011, 11111, 00011, 00011.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → out_code stable, in_ready=0. Assert reset mid-SHIFT → out_valid=0 at once, shift_state=00.

Source files
------------

// File: rtl/baudot_pkg.sv
// Shared ITA2 constants, character classes, shift-state and FSM encodings
// for the Baudot encoder, plus the letter/figure code tables.
package baudot_pkg;

    localparam logic [4:0] ITA2_LTRS  = 5'b11111;
    localparam logic [4:0] ITA2_FIGS  = 5'b11011;
    localparam logic [4:0] ITA2_CR    = 5'b01000;
    localparam logic [4:0] ITA2_LF    = 5'b00010;
    localparam logic [4:0] ITA2_SPACE = 5'b00100;
    localparam logic [4:0] ITA2_NUL   = 5'b00000;

    typedef enum logic [1:0] {
        CLS_LTRS    = 2'd0,
        CLS_FIGS    = 2'd1,
        CLS_BOTH    = 2'd2,
        CLS_INVALID = 2'd3
    } char_cls_e;

    typedef enum logic [1:0] {
        SHIFT_UNKNOWN = 2'b00,
        SHIFT_LTRS    = 2'b01,
        SHIFT_FIGS    = 2'b10
    } shift_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHAR  = 2'd2
    } enc_state_e;

    // Codes are written MSB first; bit0 is the first data bit on the line.
    function automatic logic [4:0] letter_code(input logic [7:0] up);
        case (up)
            "A": return 5'b00011;
            "B": return 5'b11001;
            "C": return 5'b01110;
            "D": return 5'b01001;
            "E": return 5'b00001;
            "F": return 5'b01101;
            "G": return 5'b11010;
            "H": return 5'b10100;
            "I": return 5'b00110;
            "J": return 5'b01011;
            "K": return 5'b01111;
            "L": return 5'b10010;
            "M": return 5'b11100;
            "N": return 5'b01100;
            "O": return 5'b11000;
            "P": return 5'b10110;
            "Q": return 5'b10111;
            "R": return 5'b01010;
            "S": return 5'b00101;
            "T": return 5'b10000;
            "U": return 5'b00111;
            "V": return 5'b11110;
            "W": return 5'b10011;
            "X": return 5'b11101;
            "Y": return 5'b10101;
            "Z": return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    // Figures share the code of the letter in the same key position.
    // Returns {hit, code}.
    function automatic logic [5:0] figs_entry(input logic [7:0] c);
        case (c)
            "1":  return {1'b1, letter_code("Q")};
            "2":  return {1'b1, letter_code("W")};
            "3":  return {1'b1, letter_code("E")};
            "4":  return {1'b1, letter_code("R")};
            "5":  return {1'b1, letter_code("T")};
            "6":  return {1'b1, letter_code("Y")};
            "7":  return {1'b1, letter_code("U")};
            "8":  return {1'b1, letter_code("I")};
            "9":  return {1'b1, letter_code("O")};
            "0":  return {1'b1, letter_code("P")};
            "-":  return {1'b1, letter_code("A")};
            "?":  return {1'b1, letter_code("B")};
            ":":  return {1'b1, letter_code("C")};
            "(":  return {1'b1, letter_code("K")};
            ")":  return {1'b1, letter_code("L")};
            ".":  return {1'b1, letter_code("M")};
            ",":  return {1'b1, letter_code("N")};
            "'":  return {1'b1, letter_code("S")};
            "/":  return {1'b1, letter_code("X")};
            "+":  return {1'b1, letter_code("Z")};
            "=":  return {1'b1, letter_code("V")};
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/baudot_encoder_lut.sv
// ASCII to ITA2 lookup: pure combinational, folds lower case to upper case
// and reports the character class alongside the 5-bit code.
module baudot_lut
    import baudot_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [4:0] code,
    output logic [1:0] cls
);

    logic [7:0] upper;
    logic [5:0] fig;

    always_comb begin
        upper = ascii;
        if (ascii >= "a" && ascii <= "z") begin
            upper = ascii - 8'd32;
        end
        fig  = figs_entry(upper);
        code = ITA2_NUL;
        cls  = CLS_INVALID;
        if (upper >= "A" && upper <= "Z") begin
            code = letter_code(upper);
            cls  = CLS_LTRS;
        end else if (fig[5]) begin
            code = fig[4:0];
            cls  = CLS_FIGS;
        end else begin
            case (upper)
                8'h20: begin code = ITA2_SPACE; cls = CLS_BOTH; end
                8'h0D: begin code = ITA2_CR;    cls = CLS_BOTH; end
                8'h0A: begin code = ITA2_LF;    cls = CLS_BOTH; end
                8'h00: begin code = ITA2_NUL;   cls = CLS_BOTH; end
                default: begin code = ITA2_NUL; cls = CLS_INVALID; end
            endcase
        end
    end

endmodule

// File: rtl/baudot_encoder.sv
// ASCII-to-ITA2 encoder feeding the Baudot transmitter, with automatic
// LTRS/FIGS shift insertion and periodic shift refresh.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a byte; in_ready=1
//   ST_SHIFT | presenting a LTRS/FIGS shift code ahead of the character
//   ST_CHAR  | presenting the latched character code
module baudot_encoder
    import baudot_pkg::*;
#(
    parameter int SHIFT_REFRESH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] shift_state,
    output logic       err_unmapped
);

    localparam int CNT_W = (SHIFT_REFRESH > 0) ? $clog2(SHIFT_REFRESH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_REFRESH);

    enc_state_e       state;
    shift_state_e     shift_q;
    shift_state_e     shift_pend;
    shift_state_e     shift_sel;
    logic [CNT_W-1:0] refresh_cnt;
    logic [4:0]       char_code;
    logic [4:0]       lut_code;
    logic [1:0]       lut_cls;
    char_cls_e        lut_cls_e;
    logic             need_shift;

    baudot_lut u_lut (
        .ascii (in_data),
        .code  (lut_code),
        .cls   (lut_cls)
    );

    assign lut_cls_e   = char_cls_e'(lut_cls);
    assign in_ready    = (state == ST_IDLE);
    assign shift_state = shift_q;

    // BOTH-class characters only force a shift through refresh; then the
    // current shift is repeated, defaulting to LTRS while still unknown.
    always_comb begin
        need_shift = 1'b0;
        shift_sel  = SHIFT_LTRS;
        case (lut_cls_e)
            CLS_LTRS: begin
                need_shift = (shift_q != SHIFT_LTRS);
                shift_sel  = SHIFT_LTRS;
            end
            CLS_FIGS: begin
                need_shift = (shift_q != SHIFT_FIGS);
                shift_sel  = SHIFT_FIGS;
            end
            default: begin
                shift_sel = (shift_q == SHIFT_FIGS) ? SHIFT_FIGS : SHIFT_LTRS;
            end
        endcase
        if (SHIFT_REFRESH != 0 && refresh_cnt == CNT_MAX) begin
            need_shift = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_code     <= '0;
            shift_q      <= SHIFT_UNKNOWN;
            shift_pend   <= SHIFT_LTRS;
            refresh_cnt  <= '0;
            char_code    <= '0;
            err_unmapped <= 1'b0;
        end else begin
            err_unmapped <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (lut_cls_e == CLS_INVALID) begin
                            err_unmapped <= 1'b1;
                        end else begin
                            char_code <= lut_code;
                            out_valid <= 1'b1;
                            if (need_shift) begin
                                state      <= ST_SHIFT;
                                shift_pend <= shift_sel;
                                out_code   <= (shift_sel == SHIFT_FIGS) ? ITA2_FIGS : ITA2_LTRS;
                            end else begin
                                state    <= ST_CHAR;
                                out_code <= lut_code;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (out_ready) begin
                        shift_q     <= shift_pend;
                        refresh_cnt <= '0;
                        out_code    <= char_code;
                        state       <= ST_CHAR;
                    end
                end
                ST_CHAR: begin
                    if (out_ready) begin
                        if (refresh_cnt != CNT_MAX) begin
                            refresh_cnt <= refresh_cnt + 1'b1;
                        end
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baudot_encoder.sv
// Bench for baudot_encoder: two instances (refresh 8 and 2), hand vectors,
// cycle-level corner sequences, an ITA2 reference model and a LUT sweep.
module tb_baudot_encoder;
    import baudot_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [4:0] out_code  [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [1:0] shift_state [2];
    logic       err_unmapped [2];

    logic [7:0] lut_in;
    logic [4:0] lut_code;
    logic [1:0] lut_cls;

    int n_checks = 0;
    int n_errors = 0;
    int RF [2] = '{8, 2};

    int got_q [$];
    int exp_q [$];
    int err_cnt [2] = '{0, 0};
    int m_shift [2];
    int m_count [2];
    int m_err   [2];

    // Standard ITA2 letter codes in line order (first bit on the left).
    string LETTERS = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string LINE    = "11000 10011 01110 10010 10000 10110 01011 00101 01100 11010 11110 01001 00111 00110 00011 01101 11101 01010 10100 00001 11100 01111 11001 10111 10101 10001";
    string FIG_CH  = "1234567890-?:().,'/+=";
    string FIG_LT  = "QWERTYUIOPABCKLMNSXZV";
    string POOL    = "AbcEtzQ 0123456789-?:().,'/+=\r\nxY~@#";

    baudot_encoder #(.SHIFT_REFRESH(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_code(out_code[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .shift_state(shift_state[0]), .err_unmapped(err_unmapped[0])
    );

    baudot_encoder #(.SHIFT_REFRESH(2)) dut_r2 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_code(out_code[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .shift_state(shift_state[1]), .err_unmapped(err_unmapped[1])
    );

    baudot_lut u_lut (.ascii(lut_in), .code(lut_code), .cls(lut_cls));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] line_to_code(input int idx);
        logic [4:0] c;
        for (int j = 0; j < 5; j++) c[j] = (LINE[idx*6+j] == "1");
        return c;
    endfunction

    task automatic classify(input logic [7:0] ch, output char_cls_e cl, output logic [4:0] code);
        logic [7:0] u;
        u = (ch >= "a" && ch <= "z") ? ch - 8'd32 : ch;
        cl = CLS_INVALID;
        code = 5'd0;
        for (int i = 0; i < 26; i++)
            if (LETTERS[i] == u) begin cl = CLS_LTRS; code = line_to_code(i); end
        for (int i = 0; i < FIG_CH.len(); i++)
            if (FIG_CH[i] == u) begin cl = CLS_FIGS; code = line_to_code(int'(FIG_LT[i]) - 65); end
        if (u == 8'd32) begin cl = CLS_BOTH; code = 5'b00100; end
        if (u == 8'd13) begin cl = CLS_BOTH; code = 5'b01000; end
        if (u == 8'd10) begin cl = CLS_BOTH; code = 5'b00010; end
        if (u == 8'd0)  begin cl = CLS_BOTH; code = 5'b00000; end
    endtask

    // Model: 0 unknown, 1 LTRS, 2 FIGS; count = characters sent since last shift.
    task automatic model_byte(input int k, input logic [7:0] ch);
        char_cls_e cl;
        logic [4:0] code;
        int sh;
        logic need;
        classify(ch, cl, code);
        if (cl == CLS_INVALID) begin
            m_err[k]++;
        end else begin
            need = (cl == CLS_LTRS && m_shift[k] != 1) || (cl == CLS_FIGS && m_shift[k] != 2) ||
                   (RF[k] != 0 && m_count[k] == RF[k]);
            if (need) begin
                sh = (cl == CLS_LTRS) ? 1 : (cl == CLS_FIGS) ? 2 : (m_shift[k] == 2) ? 2 : 1;
                exp_q.push_back(k*32 + ((sh == 2) ? 27 : 31));
                m_shift[k] = sh;
                m_count[k] = 0;
            end
            exp_q.push_back(k*32 + int'(code));
            if (m_count[k] < RF[k]) m_count[k]++;
        end
    endtask

    // One clock: log handshakes before the edge, sample #1 after it.
    task automatic tick();
        logic       st [2];
        logic [4:0] pc [2];
        for (int k = 0; k < 2; k++) begin
            st[k] = reset && out_valid[k] && !out_ready[k];
            pc[k] = out_code[k];
            if (reset && out_valid[k] && out_ready[k]) got_q.push_back(k*32 + int'(out_code[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (err_unmapped[k]) err_cnt[k]++;
            if (st[k] && reset) begin
                chk("hold_valid", {31'd0, out_valid[k]}, 32'd1);
                chk("hold_code", {27'd0, out_code[k]}, {27'd0, pc[k]});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_data[k] = 8'd0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            m_shift[k] = 0; m_count[k] = 0;
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic send(input int k, input logic [7:0] ch, input int busy);
        int n;
        n = 0;
        while (!in_ready[k] && n < 50) begin tick(); n++; end
        chk("in_ready_wait", {31'd0, in_ready[k]}, 32'd1);
        in_data[k] = ch;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        tick();
        in_valid[k] = 1'b0;
        model_byte(k, ch);
        n = 0;
        while (out_valid[k] && n < 200) begin
            out_ready[k] = ($urandom_range(99) >= busy);
            tick();
            n++;
        end
        out_ready[k] = 1'b0;
        chk("drain", {31'd0, out_valid[k]}, 32'd0);
    endtask

    typedef struct {
        int             k;
        string          s;
        int             n;
        logic [0:7][4:0] codes;
        logic [1:0]     sh;
        int             err;
    } vec_t;

    vec_t tv [10];

    initial begin
        int base, eb, rbase;
        int eb_r [2];
        logic [7:0] ch;
        char_cls_e cl;
        logic [4:0] code;
        int k;

        tv[0] = '{0, "A",    2, {5'h1F,5'h03,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b01, 0};
        tv[1] = '{0, "A1",   4, {5'h1F,5'h03,5'h1B,5'h17,5'h00,5'h00,5'h00,5'h00}, 2'b10, 0};
        tv[2] = '{0, "aa",   3, {5'h1F,5'h03,5'h03,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b01, 0};
        tv[3] = '{0, " ",    1, {5'h04,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b00, 0};
        tv[4] = '{0, "~E",   2, {5'h1F,5'h01,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b01, 1};
        tv[5] = '{1, "AAAA", 6, {5'h1F,5'h03,5'h03,5'h1F,5'h03,5'h03,5'h00,5'h00}, 2'b01, 0};
        tv[6] = '{0, "\r\n", 2, {5'h08,5'h02,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b00, 0};
        tv[7] = '{1, "   ",  4, {5'h04,5'h04,5'h1F,5'h04,5'h00,5'h00,5'h00,5'h00}, 2'b01, 0};
        tv[8] = '{0, "-?",   3, {5'h1B,5'h03,5'h19,5'h00,5'h00,5'h00,5'h00,5'h00}, 2'b10, 0};
        tv[9] = '{1, "1 2",  5, {5'h1B,5'h17,5'h04,5'h1B,5'h13,5'h00,5'h00,5'h00}, 2'b10, 0};

        lut_in = 8'd0;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = 8'd0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
        end
        #7;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", {31'd0, out_valid[i]}, 32'd0);
            chk("rst_out_code", {27'd0, out_code[i]}, 32'd0);
            chk("rst_shift", {30'd0, shift_state[i]}, 32'd0);
            chk("rst_err", {31'd0, err_unmapped[i]}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready[i]}, 32'd1);
        end

        // LUT sweep against the reference classifier.
        for (int v = 0; v < 256; v++) begin
            lut_in = 8'(v);
            #1;
            classify(lut_in, cl, code);
            chk($sformatf("lut_cls_%02h", v), {30'd0, lut_cls}, {30'd0, cl});
            if (cl != CLS_INVALID) chk($sformatf("lut_code_%02h", v), {27'd0, lut_code}, {27'd0, code});
        end

        for (int t = 0; t < 10; t++) begin
            do_reset();
            k = tv[t].k;
            base = got_q.size();
            eb = err_cnt[k];
            for (int i = 0; i < tv[t].s.len(); i++) send(k, tv[t].s[i], 0);
            chk($sformatf("vec%0d_len", t), got_q.size() - base, tv[t].n);
            for (int i = 0; i < tv[t].n; i++)
                if (base + i < got_q.size())
                    chk($sformatf("vec%0d_code%0d", t, i), got_q[base+i], k*32 + int'(tv[t].codes[i]));
            chk($sformatf("vec%0d_shift", t), {30'd0, shift_state[k]}, {30'd0, tv[t].sh});
            chk($sformatf("vec%0d_err", t), err_cnt[k] - eb, tv[t].err);
        end

        // Unmapped byte: single error pulse, no output, ready again at once.
        do_reset();
        base = got_q.size();
        in_data[0] = 8'h7E; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("unmapped_err", {31'd0, err_unmapped[0]}, 32'd1);
        chk("unmapped_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("unmapped_ready", {31'd0, in_ready[0]}, 32'd1);
        tick();
        chk("unmapped_err_end", {31'd0, err_unmapped[0]}, 32'd0);
        chk("unmapped_no_out", got_q.size() - base, 0);

        // Backpressure on both the shift and the character code.
        do_reset();
        in_data[0] = "A"; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_shift_code", {27'd0, out_code[0]}, 32'h1F);
            chk("bp_shift_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("bp_char_code", {27'd0, out_code[0]}, 32'h03);
        chk("bp_shift_upd", {30'd0, shift_state[0]}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_char_hold", {27'd0, out_code[0]}, 32'h03);
            chk("bp_char_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("bp_done_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("bp_done_ready", {31'd0, in_ready[0]}, 32'd1);

        // Reset while a FIGS shift is pending.
        in_data[0] = "1"; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        chk("mid_shift_code", {27'd0, out_code[0]}, 32'h1B);
        base = got_q.size();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("mid_rst_shift", {30'd0, shift_state[0]}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready[0]}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", {31'd0, out_valid[0]}, 32'd0);
        end
        out_ready[0] = 1'b0;
        chk("post_rst_no_out", got_q.size() - base, 0);

        // Random traffic with backpressure against the model.
        do_reset();
        exp_q.delete();
        rbase = got_q.size();
        for (int i = 0; i < 2; i++) begin m_err[i] = 0; eb_r[i] = err_cnt[i]; end
        for (int i = 0; i < 300; i++) begin
            int r;
            k = int'($urandom_range(1));
            r = int'($urandom_range(19));
            if (r < 13) ch = POOL[$urandom_range(POOL.len() - 1)];
            else if (r < 18) ch = 8'($urandom_range(255));
            else ch = 8'h00;
            send(k, ch, 35);
        end
        chk("rand_len", got_q.size() - rbase, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (rbase + i < got_q.size())
                chk($sformatf("rand_code%0d", i), got_q[rbase+i], exp_q[i]);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rand_shift%0d", i), {30'd0, shift_state[i]}, m_shift[i]);
            chk($sformatf("rand_err%0d", i), err_cnt[i] - eb_r[i], m_err[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
